// File: rtl/datapath_pkg.sv
// Shared definitions for the pipelined datapath: ALU op encodings, flag
// bit positions and the flags vector type.
package datapath_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_ADC  = 4'd8;
    localparam logic [3:0] ALU_SBB  = 4'd9;
    localparam logic [3:0] ALU_CMP  = 4'd10;
    localparam logic [3:0] ALU_PASS = 4'd11;

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
    localparam int F_P = 3;
    localparam int F_V = 4;

    typedef logic [4:0] flags_t;

    // Codes above PASS produce a zero result and leave the flags untouched.
    function automatic logic op_is_reserved(input logic [3:0] op);
        return op > ALU_PASS;
    endfunction

endpackage

// File: rtl/alu_n.sv
// Combinational ALU of generic width; arithmetic is done at WIDTH+1 bits so
// the top bit is the carry (add) or borrow (subtract).
module alu_n
    import datapath_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [3:0]       aluOp,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             C,
    output logic             N,
    output logic             P,
    output logic             V
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           cin_add;
    logic           cin_sub;

    always_comb begin
        cin_add = (aluOp == ALU_ADC) ? cin : 1'b0;
        cin_sub = (aluOp == ALU_SBB) ? cin : 1'b0;
        sum     = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, cin_add};
        diff    = {1'b0, opA} - {1'b0, opB} - {{WIDTH{1'b0}}, cin_sub};

        result = '0;
        C      = 1'b0;
        V      = 1'b0;
        case (aluOp)
            ALU_ADD, ALU_ADC: begin
                result = sum[MSB:0];
                C      = sum[WIDTH];
                V      = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]);
            end
            ALU_SUB, ALU_SBB, ALU_CMP: begin
                result = diff[MSB:0];
                C      = diff[WIDTH];
                V      = (opA[MSB] != opB[MSB]) && (diff[MSB] != opA[MSB]);
            end
            ALU_AND:  result = opA & opB;
            ALU_OR:   result = opA | opB;
            ALU_XOR:  result = opA ^ opB;
            ALU_NOT:  result = ~opA;
            ALU_SHL: begin
                result = {opA[MSB-1:0], 1'b0};
                C      = opA[MSB];
            end
            ALU_SHR: begin
                result = {1'b0, opA[MSB:1]};
                C      = opA[0];
            end
            ALU_PASS: result = opB;
            default:  result = '0;
        endcase

        Z = (result == '0);
        N = result[MSB];
        P = ~^result;
    end

endmodule

// File: rtl/pipelined_datapath.sv
// Register file + ALU + one-deep writeback register with valid/ready on both
// sides; the in-flight writeback result is forwarded to the operand reads.
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 16,
    parameter int ZERO_R0 = 0,
    localparam int SELW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             wen,
    input  logic [SELW-1:0]  selRd,
    input  logic [SELW-1:0]  selRs,
    input  logic [SELW-1:0]  selRt,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] t,
    input  logic             selT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aout,
    output logic [WIDTH-1:0] rout,
    output logic             fZ,
    output logic             fC,
    output logic             fN,
    output logic             fP,
    output logic             fV
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [SELW-1:0]  wb_rd;
    logic             wb_wen;
    flags_t           flags;
    flags_t           alu_flags;

    logic             accept;
    logic             retire;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_z, alu_c, alu_n, alu_p, alu_v;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    // The writeback register overrides the (not yet updated) register file.
    always_comb begin
        op_a = regs[selRs];
        if (out_valid && wb_wen && wb_rd == selRs) op_a = aout;
        if (ZERO_R0 != 0 && selRs == '0) op_a = '0;

        rt_val = regs[selRt];
        if (out_valid && wb_wen && wb_rd == selRt) rt_val = aout;
        if (ZERO_R0 != 0 && selRt == '0) rt_val = '0;

        op_b = selT ? t : rt_val;
    end

    assign rout = op_a;

    alu_n #(.WIDTH(WIDTH)) u_alu (
        .opA    (op_a),
        .opB    (op_b),
        .aluOp  (aluOp),
        .cin    (flags[F_C]),
        .result (alu_res),
        .Z      (alu_z),
        .C      (alu_c),
        .N      (alu_n),
        .P      (alu_p),
        .V      (alu_v)
    );

    always_comb begin
        alu_flags      = '0;
        alu_flags[F_Z] = alu_z;
        alu_flags[F_C] = alu_c;
        alu_flags[F_N] = alu_n;
        alu_flags[F_P] = alu_p;
        alu_flags[F_V] = alu_v;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (retire && wb_wen && !(ZERO_R0 != 0 && wb_rd == '0)) begin
            regs[wb_rd] <= aout;
        end
    end

    // Writeback stage: a new capture and a retire may share the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            aout      <= '0;
            wb_rd     <= '0;
            wb_wen    <= 1'b0;
            flags     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            aout      <= alu_res;
            wb_rd     <= selRd;
            wb_wen    <= wen && (aluOp != ALU_CMP);
            if (!op_is_reserved(aluOp)) flags <= alu_flags;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    assign fZ = flags[F_Z];
    assign fC = flags[F_C];
    assign fN = flags[F_N];
    assign fP = flags[F_P];
    assign fV = flags[F_V];

endmodule

// File: tb/tb_pipelined_datapath.sv
// Scoreboard bench: an architectural (in-order, no pipeline) model predicts
// each result at issue; a monitor compares on every retire.
module tb_pipelined_datapath;
    import datapath_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, wen, selT, out_ready;
    logic [3:0]  selRd, selRs, selRt, aluOp;
    logic [15:0] t;
    logic        in_ready, out_valid;
    logic [15:0] aout, rout;
    logic        fZ, fC, fN, fP, fV;

    logic        z_in_valid, z_wen, z_selT, z_out_ready;
    logic [3:0]  z_selRd, z_selRs, z_selRt, z_aluOp;
    logic [15:0] z_t;
    logic        z_in_ready, z_out_valid;
    logic [15:0] z_aout, z_rout;
    logic        z_fZ, z_fC, z_fN, z_fP, z_fV;

    pipelined_datapath #(.WIDTH(16), .NREGS(16), .ZERO_R0(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wen(wen),
        .selRd(selRd), .selRs(selRs), .selRt(selRt), .aluOp(aluOp), .t(t), .selT(selT),
        .out_valid(out_valid), .out_ready(out_ready), .aout(aout), .rout(rout),
        .fZ(fZ), .fC(fC), .fN(fN), .fP(fP), .fV(fV)
    );

    pipelined_datapath #(.WIDTH(16), .NREGS(16), .ZERO_R0(1)) u_z (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .wen(z_wen),
        .selRd(z_selRd), .selRs(z_selRs), .selRt(z_selRt), .aluOp(z_aluOp), .t(z_t), .selT(z_selT),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .aout(z_aout), .rout(z_rout),
        .fZ(z_fZ), .fC(z_fC), .fN(z_fN), .fP(z_fP), .fV(z_fV)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] r;
        logic [4:0]  f;
    } exp_t;
    exp_t sbq[$];

    logic [15:0] mregs [16];
    logic [4:0]  mflags;     // {V,P,N,C,Z}
    int          rdy_mode;   // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mflags = '0;
        sbq.delete();
    endtask

    // Reference semantics from plain integer arithmetic and range checks.
    task automatic model_exec(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                              output logic [15:0] r, output logic [4:0] f);
        int ua, ub, sa, sb, ci, full, s;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(mflags[1]);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        f = mflags;
        case (op)
            4'd0, 4'd8: begin
                if (op == 4'd0) ci = 0;
                full = ua + ub + ci;
                r = full[15:0];
                c = (full > 65535);
                s = sa + sb + ci;
                v = (s > 32767) || (s < -32768);
            end
            4'd1, 4'd9, 4'd10: begin
                if (op != 4'd9) ci = 0;
                full = ua - ub - ci;
                r = full[15:0];
                c = (ua < ub + ci);
                s = sa - sb - ci;
                v = (s > 32767) || (s < -32768);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin
                full = (ua * 2) % 65536;
                r = full[15:0];
                c = (ua >= 32768);
            end
            4'd7: begin
                full = ua / 2;
                r = full[15:0];
                c = (ua % 2) == 1;
            end
            4'd11: r = b;
            default: begin
                r = '0;
                return;
            end
        endcase
        f = {v, ($countones(r) % 2 == 0), r[15], c, (r == 16'd0)};
    endtask

    task automatic model_accept(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [15:0] imm, input logic st,
                                input logic we);
        logic [15:0] r, b;
        logic [4:0]  f;
        exp_t        e;
        b = st ? imm : mregs[rt];
        model_exec(op, mregs[rs], b, r, f);
        mflags = f;
        if (we && op != 4'd10) mregs[rd] = r;
        e.r = r;
        e.f = f;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
        else out_ready = (rdy_mode == 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [15:0] imm, input logic st,
                         input logic we);
        aluOp = op; selRd = rd; selRs = rs; selRt = rt; t = imm; selT = st; wen = we;
        in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            chk("rout_fwd", rout, mregs[rs]);
            if (in_ready) begin
                model_accept(op, rd, rs, rt, imm, st, we);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready never rose for op %0d", op);
        in_valid = 1'b0;
    endtask

    task automatic z_op(input string name, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [15:0] imm,
                        input logic st, input logic [15:0] exp);
        z_aluOp = op; z_selRd = rd; z_selRs = rs; z_selRt = rt; z_t = imm; z_selT = st;
        z_wen = 1'b1;
        z_in_valid = 1'b1;
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;
        chk(name, z_aout, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: aout=%0h with empty scoreboard", aout);
            end else begin
                e = sbq.pop_front();
                chk("retire_aout", aout, e.r);
                chk("retire_flags", {fV, fP, fN, fC, fZ}, e.f);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rimm;
        rst = 1'b0;
        in_valid = 0; wen = 0; selT = 0; out_ready = 0;
        selRd = 0; selRs = 0; selRt = 0; aluOp = 0; t = 0;
        z_in_valid = 0; z_wen = 0; z_selT = 0; z_out_ready = 1'b1;
        z_selRd = 0; z_selRs = 0; z_selRt = 0; z_aluOp = 0; z_t = 0;
        rdy_mode = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_aout", aout, 0);
        chk("rst_flags", {fV, fP, fN, fC, fZ}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        tick();

        // Register 0 hardwired to zero
        z_op("z_pass_r0", ALU_PASS, 4'd0, 4'd0, 4'd0, 16'hBEEF, 1'b1, 16'hBEEF);
        z_op("z_add_r0", ALU_ADD, 4'd1, 4'd0, 4'd0, 16'h0001, 1'b1, 16'h0001);
        z_op("z_read_r1", ALU_PASS, 4'd2, 4'd0, 4'd1, 16'h0000, 1'b0, 16'h0001);
        z_op("z_read_r0", ALU_PASS, 4'd3, 4'd0, 4'd0, 16'h0000, 1'b0, 16'h0000);

        // Reset while a result is held in writeback
        rdy_mode = 2;
        out_ready = 1'b0;
        issue(ALU_ADD, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 1'b1);
        chk("mid_out_valid", out_valid, 1);
        chk("mid_aout", aout, 16'd5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_flags", {fV, fP, fN, fC, fZ}, 0);
        chk("mid_rst_aout", aout, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        rdy_mode = 1;
        tick();
        issue(ALU_PASS, 4'd2, 4'd0, 4'd1, 16'd0, 1'b0, 1'b1);
        chk("r1_after_reset", aout, 16'd0);

        // Back-to-back forwarding
        issue(ALU_PASS, 4'd1, 4'd0, 4'd0, 16'h1234, 1'b1, 1'b1);
        issue(ALU_ADD, 4'd2, 4'd1, 4'd1, 16'd0, 1'b0, 1'b1);
        chk("fwd_aout", aout, 16'h2468);
        issue(ALU_PASS, 4'd3, 4'd0, 4'd2, 16'd0, 1'b0, 1'b1);
        chk("fwd_r2", aout, 16'h2468);

        // Carry chain
        issue(ALU_PASS, 4'd3, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b1);
        issue(ALU_ADD, 4'd1, 4'd3, 4'd0, 16'd1, 1'b1, 1'b1);
        chk("wrap_aout", aout, 16'h0000);
        chk("wrap_zc", {fZ, fC}, 2'b11);
        issue(ALU_ADC, 4'd2, 4'd0, 4'd0, 16'd0, 1'b1, 1'b1);
        chk("adc_aout", aout, 16'h0001);
        chk("adc_zc", {fZ, fC}, 2'b00);

        // Signed overflow, then flags-only compare
        issue(ALU_PASS, 4'd4, 4'd0, 4'd0, 16'h8000, 1'b1, 1'b1);
        issue(ALU_SUB, 4'd5, 4'd4, 4'd0, 16'd1, 1'b1, 1'b1);
        chk("ovf_aout", aout, 16'h7FFF);
        chk("ovf_vc", {fV, fC}, 2'b10);
        issue(ALU_CMP, 4'd6, 4'd3, 4'd3, 16'd0, 1'b0, 1'b1);
        chk("cmp_z", fZ, 1);
        issue(ALU_PASS, 4'd7, 4'd0, 4'd6, 16'd0, 1'b0, 1'b1);
        chk("cmp_no_write", aout, 16'h0000);

        // Downstream stall with a pending dependent op
        rdy_mode = 2;
        issue(ALU_ADD, 4'd8, 4'd0, 4'd0, 16'h0042, 1'b1, 1'b1);
        chk("stall_first", aout, 16'h0042);
        aluOp = ALU_SUB; selRd = 4'd9; selRs = 4'd8; selRt = 4'd0; t = 16'd2; selT = 1'b1; wen = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_aout", aout, 16'h0042);
            chk("stall_flags", {fV, fP, fN, fC, fZ}, 5'b01000);
            tick();
        end
        rdy_mode = 1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_in_ready", in_ready, 1);
        model_accept(ALU_SUB, 4'd9, 4'd8, 4'd0, 16'd2, 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("unstall_valid", out_valid, 1);
        chk("unstall_aout", aout, 16'h0040);

        // Randomised traffic with random backpressure
        rdy_mode = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                case ($urandom_range(0, 5))
                    0: rimm = 16'h0000;
                    1: rimm = 16'hFFFF;
                    2: rimm = 16'h8000;
                    3: rimm = 16'h7FFF;
                    default: rimm = 16'($urandom);
                endcase
                issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rimm,
                      1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0));
            end
        end

        rdy_mode = 1;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
        chk("drain_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
